fft_addr_sched: RTL and testbench

FFT_ADDR_SCHED -- requirements
Module: fft_addr_sched

---
 rtl/fft_addr_sched.sv | 175 +++++++++++++++++
 tb/tb_fft_addr_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_addr_sched.sv
// fft_addr_sched
//    Address and twiddle scheduler for an in-place radix-2 FFT of N = 2**R
//    points. After a start request it walks stages s = 0..R-1 and, inside
//    each stage, butterflies k = 0..N/2-1. It presents one beat per butterfly:
//    the two memory addresses, the twiddle ROM index and the stage number.
//    A beat advances only when the downstream side accepts it. All outputs
//    are registered.
//
// Configuration macro:
//    FFT_SCHED_GAP_EN  when defined, inserts GAP idle cycles between stages.
//                      This gives in-place memory read-after-write clearance.
//                      When undefined, stages run back-to-back and GAP is
//                      unused.
//
// Parameters:
//    R    log2 of the FFT size (>= 2)
//    N    FFT size, must equal 2**R
//    GAP  idle cycles between stages, 1..15 (gap build only)
//
// Ports:
//    i_clk               clock, rising edge
//    i_rst               synchronous active-high reset; aborts any schedule
//    i_start             begin one full schedule (honoured only when idle)
//    i_ready             downstream accepts the current beat
//    o_valid             current beat is valid
//    o_addr_a            butterfly upper-leg address
//    o_addr_b            butterfly lower-leg address
//    o_twiddle_exponent  twiddle ROM index (W_N^exp)
//    o_stage             current stage 0..R-1
//    o_busy              high from start acceptance until o_done
//    o_done              one-cycle pulse when the schedule completes
module fft_addr_sched #(
   parameter int R   = 5,
   parameter int N   = 32,
   parameter int GAP = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_ready,
   output logic                 o_valid,
   output logic [R-1:0]         o_addr_a,
   output logic [R-1:0]         o_addr_b,
   output logic [R-2:0]         o_twiddle_exponent,
   output logic [$clog2(R)-1:0] o_stage,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int SW = $clog2(R);
   localparam logic [R-2:0]  K_LAST = (R-1)'(N/2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(R - 1);

   // Elaboration-time guard against an inconsistent parameter set.
   if (R < 2 || N != (1 << R) || GAP < 1 || GAP > 15) begin : g_param_check
      $error("fft_addr_sched: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
`ifdef FFT_SCHED_GAP_EN
      ST_GAP,
`endif
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [R-1:0] a;
      logic [R-1:0] b;
      logic [R-2:0] e;
   } beat_t;

   state_t        state;
   logic [SW-1:0] s;
   logic [R-2:0]  k;

`ifdef FFT_SCHED_GAP_EN
   localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
   logic [3:0] gap_cnt;
`endif

   // Butterfly k of stage s: j = k mod 2**s picks the position inside a
   // group, and g = k >> s picks the group. The twiddle index scales j up to
   // the N-point ROM. Because j < 2**s <= 2**(R-1), its top bit is always zero.
   function automatic beat_t calc_beat(input logic [SW-1:0] st, input logic [R-2:0] kk);
      beat_t        bt;
      logic [R-1:0] span;
      logic [R-1:0] j;
      logic [R-1:0] g;
      span = R'(1) << st;
      j    = {1'b0, kk} & (span - R'(1));
      g    = {1'b0, kk} >> st;
      bt.a = ((g << st) << 1) | j;
      bt.b = bt.a + span;
      bt.e = j[R-2:0] << (S_LAST - st);
      return bt;
   endfunction

   // The next beat is computed and loaded together with the state change, so
   // every output is a plain register. In RUN o_valid is always 1, so
   // i_ready alone marks a handshake.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state              <= ST_IDLE;
         s                  <= '0;
         k                  <= '0;
`ifdef FFT_SCHED_GAP_EN
         gap_cnt            <= '0;
`endif
         o_valid            <= 1'b0;
         o_busy             <= 1'b0;
         o_done             <= 1'b0;
         o_addr_a           <= '0;
         o_addr_b           <= '0;
         o_twiddle_exponent <= '0;
         o_stage            <= '0;
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state   <= ST_RUN;
                  s       <= '0;
                  k       <= '0;
                  o_valid <= 1'b1;
                  o_busy  <= 1'b1;
                  o_stage <= '0;
                  {o_addr_a, o_addr_b, o_twiddle_exponent} <= calc_beat('0, '0);
               end
            end
            ST_RUN: begin
               if (i_ready) begin
                  if (k != K_LAST) begin
                     k <= k + (R-1)'(1);
                     {o_addr_a, o_addr_b, o_twiddle_exponent} <= calc_beat(s, k + (R-1)'(1));
                  end else if (s == S_LAST) begin
                     state   <= ST_DONE;
                     o_valid <= 1'b0;
                  end else begin
                     s       <= s + SW'(1);
                     k       <= '0;
                     o_stage <= s + SW'(1);
                     {o_addr_a, o_addr_b, o_twiddle_exponent} <= calc_beat(s + SW'(1), '0);
`ifdef FFT_SCHED_GAP_EN
                     // The first beat of the next stage is preloaded but held
                     // invalid while the gap counter runs.
                     state   <= ST_GAP;
                     o_valid <= 1'b0;
                     gap_cnt <= '0;
`endif
                  end
               end
            end
`ifdef FFT_SCHED_GAP_EN
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state   <= ST_RUN;
                  o_valid <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
`endif
            ST_DONE: begin
               o_done <= 1'b1;
               o_busy <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_addr_sched.sv
// tb_fft_addr_sched
//    Directed bench for fft_addr_sched. The main instance uses R=5/N=32.
//    A second instance uses R=2/N=4 to cover the smallest legal size.
`timescale 1ns/1ps
module tb_fft_addr_sched;

   localparam int R     = 5;
   localparam int N     = 32;
   localparam int TOTAL = R * N / 2;
`ifdef FFT_SCHED_GAP_EN
   localparam int EXP_DONE = 97;
`else
   localparam int EXP_DONE = 81;
`endif

   logic       clk = 1'b0;
   logic       rst, start, ready;
   logic       valid, busy, done;
   logic [4:0] addr_a, addr_b;
   logic [3:0] tw_exp;
   logic [2:0] stage;

   logic       rst2, start2, ready2;
   logic       valid2, busy2, done2;
   logic [1:0] addr_a2, addr_b2;
   logic [0:0] tw_exp2;
   logic [0:0] stage2;

   always #5 clk = ~clk;

   fft_addr_sched #(.R(5), .N(32), .GAP(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_ready(ready),
      .o_valid(valid), .o_addr_a(addr_a), .o_addr_b(addr_b),
      .o_twiddle_exponent(tw_exp), .o_stage(stage), .o_busy(busy), .o_done(done)
   );

   fft_addr_sched #(.R(2), .N(4), .GAP(4)) dut2 (
      .i_clk(clk), .i_rst(rst2), .i_start(start2), .i_ready(ready2),
      .o_valid(valid2), .o_addr_a(addr_a2), .o_addr_b(addr_b2),
      .o_twiddle_exponent(tw_exp2), .o_stage(stage2), .o_busy(busy2), .o_done(done2)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   int exp_a[TOTAL];
   int exp_b[TOTAL];
   int exp_e[TOTAL];
   int exp_s[TOTAL];
   int got_a[$];
   int got_b[$];
   int got_e[$];
   int got_s[$];
   int done_at, done_pulses, hold_errs, busy_errs;
   bit timed_out;

   // Reference schedule written as the classic group/offset loop nest.
   task automatic build_model();
      int idx;
      idx = 0;
      for (int st = 0; st < R; st++) begin
         int span;
         span = 1 << st;
         for (int base = 0; base < N; base += 2 * span) begin
            for (int j = 0; j < span; j++) begin
               exp_a[idx] = base + j;
               exp_b[idx] = base + j + span;
               exp_e[idx] = j * (N / (2 * span));
               exp_s[idx] = st;
               idx++;
            end
         end
      end
   endtask

   // Runs one schedule on the main instance and records every handshake.
   // mode 0: ready held high; 1: random ready; 2: ready high plus stray starts.
   task automatic run_schedule(input int mode);
      bit         stall;
      logic [4:0] sa, sb;
      logic [3:0] se;
      logic [2:0] ss;
      got_a.delete(); got_b.delete(); got_e.delete(); got_s.delete();
      done_at = -1; done_pulses = 0; hold_errs = 0; busy_errs = 0;
      timed_out = 1'b0; stall = 1'b0;
      sa = '0; sb = '0; se = '0; ss = '0;
      @(negedge clk); start = 1'b1; ready = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (done) begin
            done_pulses++;
            if (done_at < 0) done_at = n;
         end
         if (done_at < 0 && !done && !busy) busy_errs++;
         if (done_at >= 0 && n > done_at && (busy || valid)) busy_errs++;
         if (stall && {addr_a, addr_b, tw_exp, stage, valid} !== {sa, sb, se, ss, 1'b1})
            hold_errs++;
         ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (mode == 2) begin
            start = 1'b0;
            if (got_a.size() == 30 && valid) start = 1'b1;
            if (got_a.size() == TOTAL && busy && !valid && !done) start = 1'b1;
         end
         if (valid && ready) begin
            got_a.push_back(int'(addr_a));
            got_b.push_back(int'(addr_b));
            got_e.push_back(int'(tw_exp));
            got_s.push_back(int'(stage));
         end
         stall = valid && !ready;
         sa = addr_a; sb = addr_b; se = tw_exp; ss = stage;
         if (done_at >= 0 && n >= done_at + 5) break;
         @(negedge clk);
      end
      if (done_at < 0) timed_out = 1'b1;
      start = 1'b0;
      ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rst2 = 1'b1; start = 1'b1; start2 = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); end
      tests_run++;
      if ({addr_a, addr_b, tw_exp, stage} !== 17'd0) begin
         tests_failed++; $display("[TB] FAIL reset_outputs: got a=%0d b=%0d e=%0d s=%0d expected all 0", addr_a, addr_b, tw_exp, stage);
      end
      tests_run++;
      if ({valid2, busy2, done2, addr_a2, addr_b2, tw_exp2, stage2} !== 9'd0) begin
         tests_failed++; $display("[TB] FAIL reset_small: got %b expected all 0", {valid2, busy2, done2, addr_a2, addr_b2, tw_exp2, stage2});
      end
      start = 1'b0; start2 = 1'b0;
      @(negedge clk); rst = 1'b0; rst2 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_schedule();
      int bad;
      run_schedule(0);
      tests_run++;
      if (timed_out) begin tests_failed++; $display("[TB] FAIL full_timeout: got no o_done expected o_done within budget"); end
      tests_run++;
      if (got_a.size() != TOTAL) begin tests_failed++; $display("[TB] FAIL full_count: got %0d handshakes expected %0d", got_a.size(), TOTAL); end
      bad = 0;
      for (int i = 0; i < TOTAL && i < got_a.size(); i++) begin
         tests_run++;
         if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_e[i] !== exp_e[i] || got_s[i] !== exp_s[i]) begin
            tests_failed++;
            if (bad < 8) $display("[TB] FAIL full_beat%0d: got (%0d,%0d,%0d,s%0d) expected (%0d,%0d,%0d,s%0d)",
                                  i, got_a[i], got_b[i], got_e[i], got_s[i], exp_a[i], exp_b[i], exp_e[i], exp_s[i]);
            bad++;
         end
      end
      tests_run++;
      if (got_a.size() < 68 || got_a[0] !== 0 || got_b[0] !== 1 || got_e[0] !== 0 || got_s[0] !== 0) begin
         tests_failed++; $display("[TB] FAIL hand_beat0: got size %0d expected a=0 b=1 e=0 s=0", got_a.size());
      end
      tests_run++;
      if (got_a.size() < 68 || got_a[17] !== 1 || got_b[17] !== 3 || got_e[17] !== 8 || got_s[17] !== 1) begin
         tests_failed++; $display("[TB] FAIL hand_s1k1: got size %0d expected a=1 b=3 e=8 s=1", got_a.size());
      end
      tests_run++;
      if (got_a.size() < 68 || got_a[67] !== 3 || got_b[67] !== 19 || got_e[67] !== 3 || got_s[67] !== 4) begin
         tests_failed++; $display("[TB] FAIL hand_s4k3: got size %0d expected a=3 b=19 e=3 s=4", got_a.size());
      end
      tests_run++;
      if (done_at !== EXP_DONE) begin tests_failed++; $display("[TB] FAIL full_done_time: got %0d expected %0d", done_at, EXP_DONE); end
      tests_run++;
      if (done_pulses !== 1) begin tests_failed++; $display("[TB] FAIL full_done_pulses: got %0d expected 1", done_pulses); end
      tests_run++;
      if (busy_errs !== 0) begin tests_failed++; $display("[TB] FAIL full_busy: got %0d busy errors expected 0", busy_errs); end
   endtask

   task automatic test_ready_toggle();
      int bad;
      run_schedule(1);
      tests_run++;
      if (timed_out || got_a.size() != TOTAL) begin
         tests_failed++; $display("[TB] FAIL toggle_count: got %0d handshakes (timeout=%0d) expected %0d", got_a.size(), timed_out, TOTAL);
      end
      bad = 0;
      for (int i = 0; i < TOTAL && i < got_a.size(); i++) begin
         if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_e[i] !== exp_e[i] || got_s[i] !== exp_s[i]) bad++;
      end
      tests_run++;
      if (bad !== 0) begin tests_failed++; $display("[TB] FAIL toggle_sequence: got %0d wrong beats expected 0", bad); end
      tests_run++;
      if (hold_errs !== 0) begin tests_failed++; $display("[TB] FAIL toggle_hold: got %0d unstable stalls expected 0", hold_errs); end
      tests_run++;
      if (done_pulses !== 1 || busy_errs !== 0) begin
         tests_failed++; $display("[TB] FAIL toggle_done: got %0d pulses %0d busy errors expected 1 and 0", done_pulses, busy_errs);
      end
   endtask

   task automatic test_start_ignored();
      int bad;
      run_schedule(2);
      bad = 0;
      for (int i = 0; i < TOTAL && i < got_a.size(); i++) begin
         if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_e[i] !== exp_e[i] || got_s[i] !== exp_s[i]) bad++;
      end
      tests_run++;
      if (got_a.size() != TOTAL || bad !== 0) begin
         tests_failed++; $display("[TB] FAIL start_ignored_sequence: got %0d beats %0d wrong expected %0d beats 0 wrong", got_a.size(), bad, TOTAL);
      end
      tests_run++;
      if (done_at !== EXP_DONE || done_pulses !== 1) begin
         tests_failed++; $display("[TB] FAIL start_ignored_done: got at %0d pulses %0d expected at %0d pulses 1", done_at, done_pulses, EXP_DONE);
      end
      tests_run++;
      if (busy_errs !== 0) begin tests_failed++; $display("[TB] FAIL start_ignored_restart: got %0d busy errors expected 0", busy_errs); end
   endtask

   task automatic test_reset_mid();
      bit found;
      int bad;
      found = 1'b0;
      @(negedge clk); start = 1'b1; ready = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (valid && stage == 3'd2) begin found = 1'b1; break; end
         @(negedge clk);
      end
      tests_run++;
      if (!found) begin tests_failed++; $display("[TB] FAIL reset_mid_reach: got no stage 2 beat expected one within budget"); end
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({valid, busy, done, addr_a, addr_b, tw_exp, stage} !== 20'd0) begin
         tests_failed++; $display("[TB] FAIL reset_mid_outputs: got %b expected all 0", {valid, busy, done, addr_a, addr_b, tw_exp, stage});
      end
      rst = 1'b0; start = 1'b0;
      bad = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (done || busy || valid) bad++;
      end
      tests_run++;
      if (bad !== 0) begin tests_failed++; $display("[TB] FAIL reset_mid_idle: got %0d active cycles expected 0", bad); end
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      tests_run++;
      if ({valid, busy, addr_a, addr_b, tw_exp, stage} !== {1'b1, 1'b1, 5'd0, 5'd1, 4'd0, 3'd0}) begin
         tests_failed++; $display("[TB] FAIL reset_mid_restart: got v=%b busy=%b a=%0d b=%0d e=%0d s=%0d expected v=1 busy=1 a=0 b=1 e=0 s=0",
                                  valid, busy, addr_a, addr_b, tw_exp, stage);
      end
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_r2();
      int ea[4], eb[4], ee[4], es[4];
      int ga[$], gb[$], ge[$], gs[$];
      bit seen;
      int bad;
      ea = '{0, 2, 0, 1}; eb = '{1, 3, 2, 3}; ee = '{0, 0, 0, 1}; es = '{0, 0, 1, 1};
      seen = 1'b0;
      ready2 = 1'b1;
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      tests_run++;
      if (busy2 !== 1'b1) begin tests_failed++; $display("[TB] FAIL r2_busy: got %b expected 1", busy2); end
      for (int n = 0; n < 200; n++) begin
         if (done2) begin seen = 1'b1; break; end
         if (valid2 && ready2) begin
            ga.push_back(int'(addr_a2)); gb.push_back(int'(addr_b2));
            ge.push_back(int'(tw_exp2)); gs.push_back(int'(stage2));
         end
         @(negedge clk);
      end
      tests_run++;
      if (!seen || ga.size() != 4) begin
         tests_failed++; $display("[TB] FAIL r2_count: got %0d beats done=%0d expected 4 beats and done", ga.size(), seen);
      end
      bad = 0;
      for (int i = 0; i < 4 && i < ga.size(); i++) begin
         tests_run++;
         if (ga[i] !== ea[i] || gb[i] !== eb[i] || ge[i] !== ee[i] || gs[i] !== es[i]) begin
            tests_failed++;
            $display("[TB] FAIL r2_beat%0d: got (%0d,%0d,%0d,s%0d) expected (%0d,%0d,%0d,s%0d)",
                     i, ga[i], gb[i], ge[i], gs[i], ea[i], eb[i], ee[i], es[i]);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ready = 1'b1;
      rst2 = 1'b1; start2 = 1'b0; ready2 = 1'b1;
      build_model();
      test_reset();
      test_full_schedule();
      test_ready_toggle();
      test_start_ignored();
      test_reset_mid();
      test_r2();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
